// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: data/address widths, CSR map, and field bit positions.
// Latency: none (constants and a pure helper function only).
// Backpressure: none.
package csr_file_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int CSR_ADDR_WIDTH = 12;

   typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;
   typedef logic [DATA_WIDTH-1:0]     csr_data_t;

   // Machine-mode CSRs
   localparam csr_addr_t CSR_MSTATUS   = 12'h300;
   localparam csr_addr_t CSR_MIE       = 12'h304;
   localparam csr_addr_t CSR_MTVEC     = 12'h305;
   localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
   localparam csr_addr_t CSR_MEPC      = 12'h341;
   localparam csr_addr_t CSR_MCAUSE    = 12'h342;
   localparam csr_addr_t CSR_MIP       = 12'h344;
   localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
   localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
   localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
   localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
   // Read-only user shadows of the counters
   localparam csr_addr_t CSR_CYCLE     = 12'hC00;
   localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
   localparam csr_addr_t CSR_INSTRET   = 12'hC02;
   localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

   // mstatus fields
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   // mip / mie interrupt bits
   localparam int IRQ_MTI = 7;
   localparam int IRQ_MEI = 11;

   localparam csr_data_t MIE_WMASK = csr_data_t'((1 << IRQ_MTI) | (1 << IRQ_MEI));

   // Architectural mstatus view: MPP hardwired to machine mode (2'b11).
   function automatic csr_data_t mstatus_pack(input logic mie, input logic mpie);
      csr_data_t v;
      v = '0;
      v[12:11]        = 2'b11;
      v[MSTATUS_MIE]  = mie;
      v[MSTATUS_MPIE] = mpie;
      return v;
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter with independently writable 32-bit halves (mcycle / minstret).
// Latency: write or increment visible on count_o one cycle after the edge.
// Backpressure: none; a half-write freezes the other half for that cycle.
module csr_counter64
   import csr_file_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  inc_i,
   input  logic                  we_lo_i,
   input  logic                  we_hi_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [63:0]           count_o
);

   logic [63:0] count_q;

   // Software write replaces one half without increment/carry; otherwise count up with full 64-bit carry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (we_lo_i || we_hi_i) begin
         if (we_lo_i) count_q[31:0]  <= wdata_i;
         if (we_hi_i) count_q[63:32] <= wdata_i;
      end else if (inc_i) begin
         count_q <= count_q + 64'd1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: WB-stage writes, trap/mret updates, 64-bit counters, one combinational read port.
// Latency: writes land at the next edge; the read port bypasses a same-address write in flight.
// Backpressure: none; every write, trap and mret is accepted in the cycle it is presented.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = 32'h0000_0000
)
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      csr_we_i,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
   input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
   input  logic                      instret_incr_i,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
   output logic [DATA_WIDTH-1:0]     csr_rdata_o,
   input  logic                      trap_i,
   input  logic [DATA_WIDTH-1:0]     trap_epc_i,
   input  logic [DATA_WIDTH-1:0]     trap_cause_i,
   input  logic                      mret_i,
   input  logic                      irq_timer_i,
   input  logic                      irq_ext_i,
   output logic [DATA_WIDTH-1:0]     mtvec_o,
   output logic [DATA_WIDTH-1:0]     mepc_o,
   output logic                      mstatus_mie_o,
   output logic [DATA_WIDTH-1:0]     mie_o
);

   logic            mst_mie_q, mst_mpie_q;
   csr_data_t       mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [63:0]     mcycle, minstret;
   csr_data_t       mip_val;
   csr_data_t       wr_masked;
   logic            wr_legal;

   assign mip_val = csr_data_t'({irq_ext_i, 3'b000, irq_timer_i, 7'b0});

   csr_counter64 u_mcycle (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (1'b1),
      .we_lo_i (csr_we_i && csr_waddr_i == CSR_MCYCLE),
      .we_hi_i (csr_we_i && csr_waddr_i == CSR_MCYCLEH),
      .wdata_i (csr_wdata_i),
      .count_o (mcycle)
   );

   csr_counter64 u_minstret (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (instret_incr_i),
      .we_lo_i (csr_we_i && csr_waddr_i == CSR_MINSTRET),
      .we_hi_i (csr_we_i && csr_waddr_i == CSR_MINSTRETH),
      .wdata_i (csr_wdata_i),
      .count_o (minstret)
   );

   // Write data as it will appear when read back; shared by the bypass path. Shadows, mip and holes are not writable.
   always_comb begin
      wr_masked = '0;
      wr_legal  = 1'b1;
      case (csr_waddr_i)
         CSR_MSTATUS:  wr_masked = mstatus_pack(csr_wdata_i[MSTATUS_MIE], csr_wdata_i[MSTATUS_MPIE]);
         CSR_MIE:      wr_masked = csr_wdata_i & MIE_WMASK;
         CSR_MEPC:     wr_masked = {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
         CSR_MTVEC, CSR_MSCRATCH, CSR_MCAUSE,
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
                       wr_masked = csr_wdata_i;
         default:      wr_legal  = 1'b0;
      endcase
   end

   // Register updates; trap beats mret beats a software write on overlapping fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         if (csr_we_i) begin
            case (csr_waddr_i)
               CSR_MSTATUS: begin
                  mst_mie_q  <= csr_wdata_i[MSTATUS_MIE];
                  mst_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
               end
               CSR_MIE:      mie_q      <= csr_wdata_i & MIE_WMASK;
               CSR_MTVEC:    mtvec_q    <= csr_wdata_i;
               CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
               CSR_MEPC:     mepc_q     <= {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
               CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
               default: ;
            endcase
         end
         if (trap_i) begin
            mepc_q     <= {trap_epc_i[DATA_WIDTH-1:2], 2'b00};
            mcause_q   <= trap_cause_i;
            mst_mpie_q <= mst_mie_q;
            mst_mie_q  <= 1'b0;
         end else if (mret_i) begin
            mst_mie_q  <= mst_mpie_q;
            mst_mpie_q <= 1'b1;
         end
      end
   end

   // Combinational read port with same-address write bypass.
   always_comb begin
      csr_rdata_o = '0;
      if (csr_we_i && wr_legal && csr_waddr_i == csr_raddr_i) begin
         csr_rdata_o = wr_masked;
      end else begin
         case (csr_raddr_i)
            CSR_MSTATUS:                  csr_rdata_o = mstatus_pack(mst_mie_q, mst_mpie_q);
            CSR_MIE:                      csr_rdata_o = mie_q;
            CSR_MTVEC:                    csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:                 csr_rdata_o = mscratch_q;
            CSR_MEPC:                     csr_rdata_o = mepc_q;
            CSR_MCAUSE:                   csr_rdata_o = mcause_q;
            CSR_MIP:                      csr_rdata_o = mip_val;
            CSR_MCYCLE,    CSR_CYCLE:     csr_rdata_o = mcycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:    csr_rdata_o = mcycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:   csr_rdata_o = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  csr_rdata_o = minstret[63:32];
            default:                      csr_rdata_o = '0;
         endcase
      end
   end

   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;
   assign mstatus_mie_o = mst_mie_q;
   assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model advances once per rising edge; read port checked 1ns after inputs change.
// Backpressure: not applicable.
module tb_csr_file;

   localparam logic [31:0] MTVEC_RST = 32'h8000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        instret_incr;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        trap;
   logic [31:0] trap_epc;
   logic [31:0] trap_cause;
   logic        mret;
   logic        irq_timer;
   logic        irq_ext;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;
   logic        mstatus_mie_out;
   logic [31:0] mie_out;

   always #5 clk = ~clk;

   csr_file #(.MTVEC_RESET(MTVEC_RST)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .csr_we_i       (csr_we),
      .csr_waddr_i    (csr_waddr),
      .csr_wdata_i    (csr_wdata),
      .instret_incr_i (instret_incr),
      .csr_raddr_i    (csr_raddr),
      .csr_rdata_o    (csr_rdata),
      .trap_i         (trap),
      .trap_epc_i     (trap_epc),
      .trap_cause_i   (trap_cause),
      .mret_i         (mret),
      .irq_timer_i    (irq_timer),
      .irq_ext_i      (irq_ext),
      .mtvec_o        (mtvec_out),
      .mepc_o         (mepc_out),
      .mstatus_mie_o  (mstatus_mie_out),
      .mie_o          (mie_out)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   longint unsigned m_cycle, m_instret;
   bit          m_st_mie, m_st_mpie;
   logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;

   logic [11:0] addr_tbl [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00,
                                  12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cycle = 0; m_instret = 0;
      m_st_mie = 0; m_st_mpie = 0;
      m_mie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
   endtask

   function automatic logic [31:0] mstatus_view(input bit mie, input bit mpie);
      return 32'h0000_1800 + (mpie ? 32'h80 : 32'h0) + (mie ? 32'h8 : 32'h0);
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return mstatus_view(m_st_mie, m_st_mpie);
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return (irq_timer ? 32'h80 : 32'h0) + (irq_ext ? 32'h800 : 32'h0);
         12'hB00, 12'hC00: return 32'(m_cycle);
         12'hB80, 12'hC80: return 32'(m_cycle >> 32);
         12'hB02, 12'hC02: return 32'(m_instret);
         12'hB82, 12'hC82: return 32'(m_instret >> 32);
         default: return 32'h0;
      endcase
   endfunction

   // Value a software write leaves readable at an address; writable reports whether it sticks at all.
   function automatic logic [31:0] written_view(input logic [11:0] a, input logic [31:0] d, output bit writable);
      writable = 1;
      case (a)
         12'h300: return mstatus_view(d[3], d[7]);
         12'h304: return d & 32'h0000_0880;
         12'h341: return d & 32'hFFFF_FFFC;
         12'h305, 12'h340, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82: return d;
         default: begin writable = 0; return 32'h0; end
      endcase
   endfunction

   function automatic logic [31:0] exp_rdata();
      bit w;
      logic [31:0] v;
      v = written_view(csr_waddr, csr_wdata, w);
      if (csr_we && w && csr_waddr == csr_raddr) return v;
      return model_read(csr_raddr);
   endfunction

   task automatic model_clock();
      longint unsigned c, n;
      bit old_mie, old_mpie;
      if (rst) begin
         model_reset();
         return;
      end
      old_mie = m_st_mie; old_mpie = m_st_mpie;
      c = m_cycle + 1;
      n = m_instret + (instret_incr ? 1 : 0);
      if (csr_we) begin
         case (csr_waddr)
            12'hB00: c = (m_cycle & 64'hFFFF_FFFF_0000_0000) | longint'(csr_wdata);
            12'hB80: c = (longint'(csr_wdata) << 32) | (m_cycle & 64'h0000_0000_FFFF_FFFF);
            12'hB02: n = (m_instret & 64'hFFFF_FFFF_0000_0000) | longint'(csr_wdata);
            12'hB82: n = (longint'(csr_wdata) << 32) | (m_instret & 64'h0000_0000_FFFF_FFFF);
            12'h300: begin m_st_mie = csr_wdata[3]; m_st_mpie = csr_wdata[7]; end
            12'h304: m_mie = csr_wdata & 32'h0000_0880;
            12'h305: m_mtvec = csr_wdata;
            12'h340: m_mscratch = csr_wdata;
            12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
            12'h342: m_mcause = csr_wdata;
            default: ;
         endcase
      end
      if (trap) begin
         m_mepc = trap_epc & 32'hFFFF_FFFC;
         m_mcause = trap_cause;
         m_st_mpie = old_mie;
         m_st_mie = 0;
      end else if (mret) begin
         m_st_mie = old_mpie;
         m_st_mpie = 1;
      end
      m_cycle = c;
      m_instret = n;
   endtask

   task automatic drive(input bit we, input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra);
      rst = 0; csr_we = we; csr_waddr = wa; csr_wdata = wd; csr_raddr = ra;
      instret_incr = 0; trap = 0; trap_epc = 0; trap_cause = 0; mret = 0; irq_timer = 0; irq_ext = 0;
   endtask

   // One clock: read port checked before the edge, exported registers checked after it.
   task automatic step();
      #1;
      chk("rdata", {32'h0, csr_rdata}, {32'h0, exp_rdata()});
      @(posedge clk);
      model_clock();
      @(negedge clk);
      chk("mtvec_o", {32'h0, mtvec_out}, {32'h0, m_mtvec});
      chk("mepc_o", {32'h0, mepc_out}, {32'h0, m_mepc});
      chk("mstatus_mie_o", {63'h0, mstatus_mie_out}, {63'h0, m_st_mie});
      chk("mie_o", {32'h0, mie_out}, {32'h0, m_mie});
   endtask

   initial begin
      drive(0, 12'h0, 32'h0, 12'h0);
      rst = 1;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      chk("rst_mtvec_o", {32'h0, mtvec_out}, {32'h0, MTVEC_RST});
      chk("rst_mepc_o", {32'h0, mepc_out}, 64'h0);
      chk("rst_mie_bit", {63'h0, mstatus_mie_out}, 64'h0);
      chk("rst_mie_o", {32'h0, mie_out}, 64'h0);

      // Idle five cycles after reset
      drive(0, 12'h0, 32'h0, 12'hB00);
      repeat (5) step();
      #1;
      chk("mcycle_after_5", {32'h0, csr_rdata}, 64'd5);
      csr_raddr = 12'hB02; #1;
      chk("minstret_idle", {32'h0, csr_rdata}, 64'd0);
      csr_raddr = 12'h7C0; #1;
      chk("unmapped_read", {32'h0, csr_rdata}, 64'd0);

      // mscratch bypass then settled value
      drive(1, 12'h340, 32'hDEAD_BEEF, 12'h340);
      #1 chk("mscratch_bypass", {32'h0, csr_rdata}, 64'hDEAD_BEEF);
      step();
      drive(0, 12'h0, 32'h0, 12'h340);
      #1 chk("mscratch_held", {32'h0, csr_rdata}, 64'hDEAD_BEEF);
      step();

      // mepc low bits, mstatus field masking
      drive(1, 12'h341, 32'h0000_1003, 12'h341);
      step();
      chk("mepc_o_aligned", {32'h0, mepc_out}, 64'h1000);
      drive(1, 12'h300, 32'hFFFF_FFFF, 12'h000);
      step();
      drive(0, 12'h0, 32'h0, 12'h300);
      #1 chk("mstatus_mask", {32'h0, csr_rdata}, 64'h1888);
      step();

      // mcycle preload and carry into the high half
      drive(1, 12'hB00, 32'hFFFF_FFFF, 12'hB80);
      step();
      drive(1, 12'hB80, 32'h0, 12'hB00);
      step();
      drive(0, 12'h0, 32'h0, 12'hB00);
      step();
      #1 chk("mcycle_lo_wrap", {32'h0, csr_rdata}, 64'h0);
      csr_raddr = 12'hB80; #1;
      chk("mcycle_hi_carry", {32'h0, csr_rdata}, 64'h1);
      drive(1, 12'hC00, 32'h1234_5678, 12'hC00);
      step();
      drive(0, 12'h0, 32'h0, 12'hB00);
      step();

      // Trap beats a same-cycle mepc write, then mret restores MIE
      drive(1, 12'h300, 32'h0000_0008, 12'h300);
      step();
      drive(1, 12'h341, 32'h0000_0400, 12'h342);
      trap = 1; trap_epc = 32'h0000_0200; trap_cause = 32'h8000_0007;
      step();
      chk("trap_mepc_o", {32'h0, mepc_out}, 64'h200);
      chk("trap_mie_clr", {63'h0, mstatus_mie_out}, 64'h0);
      drive(0, 12'h0, 32'h0, 12'h300);
      #1 chk("trap_mstatus", {32'h0, csr_rdata}, 64'h1880);
      csr_raddr = 12'h342; #1;
      chk("trap_mcause", {32'h0, csr_rdata}, 64'h8000_0007);
      mret = 1; csr_raddr = 12'h300;
      step();
      drive(0, 12'h0, 32'h0, 12'h300);
      #1 chk("mret_mstatus", {32'h0, csr_rdata}, 64'h1888);
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 99) < 2);
         csr_we       = $urandom_range(0, 1) == 1;
         csr_waddr    = addr_tbl[$urandom_range(0, 15)];
         csr_wdata    = $urandom;
         csr_raddr    = ($urandom_range(0, 3) == 0) ? csr_waddr : addr_tbl[$urandom_range(0, 15)];
         instret_incr = $urandom_range(0, 1) == 1;
         trap         = ($urandom_range(0, 9) == 0);
         trap_epc     = $urandom;
         trap_cause   = $urandom;
         mret         = ($urandom_range(0, 9) == 0);
         irq_timer    = $urandom_range(0, 1) == 1;
         irq_ext      = $urandom_range(0, 1) == 1;
         step();
      end

      // Reset wins over a retire on the same cycle
      drive(1, 12'h305, 32'h1234_5670, 12'hB02);
      step();
      drive(1, 12'h304, 32'hFFFF_FFFF, 12'hB02);
      instret_incr = 1;
      step();
      drive(0, 12'h0, 32'h0, 12'hB02);
      instret_incr = 1;
      step();
      instret_incr = 1; rst = 1;
      step();
      drive(0, 12'h0, 32'h0, 12'hB02);
      #1 chk("rst_minstret", {32'h0, csr_rdata}, 64'h0);
      chk("rst2_mtvec_o", {32'h0, mtvec_out}, {32'h0, MTVEC_RST});
      chk("rst2_mepc_o", {32'h0, mepc_out}, 64'h0);
      chk("rst2_mie_bit", {63'h0, mstatus_mie_out}, 64'h0);
      chk("rst2_mie_o", {32'h0, mie_out}, 64'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
